// File: rtl/tag_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tag_queue_pkg
// Description : Shared types and default sizes for the tag queue controller.
// Revision    : 1.0 - initial release
// ============================================================================
package tag_queue_pkg;

  // Default sizing: 9-bit rename/issue tags, eight-entry queue.
  localparam int c_def_width = 9;
  localparam int c_def_depth = 8;

  // One stored tag word.
  typedef logic [c_def_width-1:0] tag_t;

  // Read/write pointer into the word bank.
  typedef logic [$clog2(c_def_depth)-1:0] ptr_t;

endpackage
`default_nettype wire

// File: rtl/tag_word_reg.sv
`default_nettype none
// ============================================================================
// Module      : tag_word_reg
// Description : One storage word of the tag queue: a WIDTH-bit register that
//               loads only when its enable is high, cleared by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_word_reg #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,   // asynchronous, active-low
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Capture the incoming tag only when this word is the write target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/tag_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tag_queue_ctrl
// Description : Circular FIFO controller for a bank of tag words. Produces the
//               one-hot word enables, read/write pointers, occupancy count and
//               valid/ready handshakes, with a single-cycle flush used for
//               branch-mispredict recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_queue_ctrl
  import tag_queue_pkg::*;
#(
  parameter int WIDTH = c_def_width,
  parameter int DEPTH = c_def_depth,   // power of two, at least 2
  parameter int CNTW  = $clog2(DEPTH + 1)  // derived, leave at default
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data,
  input  logic             flush,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty
);

  localparam int              c_ptrw       = $clog2(DEPTH);
  localparam logic [CNTW-1:0] c_full_count = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] c_cnt_one    = CNTW'(1);
  localparam logic [c_ptrw-1:0] c_ptr_one  = c_ptrw'(1);

  logic [c_ptrw-1:0] r_wr_ptr;
  logic [c_ptrw-1:0] r_rd_ptr;
  logic [CNTW-1:0]   r_count;

  logic              w_enq_fire;
  logic              w_deq_fire;
  logic [DEPTH-1:0]  w_wen;
  logic [WIDTH-1:0]  w_words [DEPTH];

  // Flags derive from the registered count only, so enq_ready never sees
  // deq_ready combinationally: a full queue refuses the enqueue even in the
  // cycle it is being drained.
  assign full      = (r_count == c_full_count);
  assign empty     = (r_count == '0);
  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign count     = r_count;

  // A flush cycle swallows both transfers regardless of the handshakes.
  assign w_enq_fire = enq_valid & enq_ready & ~flush;
  assign w_deq_fire = deq_valid & deq_ready & ~flush;

  // Head word is presented straight from storage; no fall-through path.
  assign deq_data = w_words[r_rd_ptr];

  // Word bank: each word loads only when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_words
    assign w_wen[gi] = w_enq_fire && (r_wr_ptr == c_ptrw'(gi));

    tag_word_reg #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_wen[gi]),
      .i_d   (enq_data),
      .o_q   (w_words[gi])
    );
  end

  // Pointer advance; DEPTH is a power of two so wrap is the natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_enq_fire) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_deq_fire) r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  // Occupancy tracking; handshakes keep it within 0..DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tag_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tag_queue_ctrl
// Description : Self-checking bench for tag_queue_ctrl. Directed stimulus
//               pushes expected tags into a scoreboard; a negedge monitor pops
//               and compares on every dequeue and checks the flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tag_queue_ctrl;
  import tag_queue_pkg::*;

  localparam int WIDTH = 9;
  localparam int DEPTH = 8;
  localparam int CNTW  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_data;
  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_data;
  logic             flush;
  logic [CNTW-1:0]  count;
  logic             full;
  logic             empty;

  int   checks   = 0;
  int   failures = 0;
  int   mcount   = 0;
  tag_t exp_q[$];

  always #5 clk = ~clk;

  tag_queue_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data),
    .flush     (flush),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: flags against the occupancy model, dequeued data against scoreboard.
  always @(negedge clk) begin
    tag_t e;
    if (reset) begin
      check("count",     32'(count),     32'(mcount));
      check("full",      32'(full),      32'(mcount == DEPTH));
      check("empty",     32'(empty),     32'(mcount == 0));
      check("enq_ready", 32'(enq_ready), 32'(mcount != DEPTH));
      check("deq_valid", 32'(deq_valid), 32'(mcount != 0));
      if (deq_valid && deq_ready && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL deq_underflow: got %0h expected no dequeue", deq_data);
        end else begin
          e = exp_q.pop_front();
          check("deq_data", 32'(deq_data), 32'(e));
        end
      end
    end
  end

  // One clock of stimulus; the occupancy model advances at the edge.
  task automatic step(input logic ev, input logic [WIDTH-1:0] d, input logic dr, input logic fl);
    logic ef, df;
    enq_valid = ev;
    enq_data  = d;
    deq_ready = dr;
    flush     = fl;
    @(posedge clk);
    ef = ev && (mcount != DEPTH) && !fl;
    df = dr && (mcount != 0) && !fl;
    if (fl) begin
      mcount = 0;
      exp_q.delete();
    end else begin
      if (ef) exp_q.push_back(d);
      if (ef && !df) mcount++;
      else if (df && !ef) mcount--;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;

    // Reset state, observed before any clock edge.
    #3;
    check("rst_count",     32'(count),     32'd0);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_full",      32'(full),      32'd0);
    check("rst_enq_ready", 32'(enq_ready), 32'd1);
    check("rst_deq_valid", 32'(deq_valid), 32'd0);
    check("rst_deq_data",  32'(deq_data),  32'd0);
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: three enqueues then three dequeues.
    step(1'b1, 9'h0A1, 1'b0, 1'b0); check("t1_cnt1", 32'(count), 32'd1);
    step(1'b1, 9'h0A2, 1'b0, 1'b0); check("t1_cnt2", 32'(count), 32'd2);
    step(1'b1, 9'h0A3, 1'b0, 1'b0); check("t1_cnt3", 32'(count), 32'd3);
    check("t1_head", 32'(deq_data), 32'h0A1);
    step(1'b0, '0, 1'b1, 1'b0); check("t1_cnt2d", 32'(count), 32'd2);
    check("t1_head2", 32'(deq_data), 32'h0A2);
    step(1'b0, '0, 1'b1, 1'b0); check("t1_cnt1d", 32'(count), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0); check("t1_cnt0d", 32'(count), 32'd0);
    check("t1_empty", 32'(empty), 32'd1);

    // Test 2: fill, hold a rejected enqueue, drain.
    for (int i = 0; i < 8; i++) step(1'b1, 9'(9'h100 + i), 1'b0, 1'b0);
    check("t2_full",      32'(full),      32'd1);
    check("t2_enq_ready", 32'(enq_ready), 32'd0);
    check("t2_count",     32'(count),     32'd8);
    repeat (3) step(1'b1, 9'h1FF, 1'b0, 1'b0);
    check("t2_count_hold", 32'(count), 32'd8);
    check("t2_head", 32'(deq_data), 32'h100);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("t2_empty", 32'(empty), 32'd1);

    // Test 3: realign to word 0, fill, simultaneous enq/deq while full.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 9'(9'h130 + i), 1'b0, 1'b0);
    step(1'b1, 9'h1EE, 1'b1, 1'b0);
    check("t3_count7",    32'(count),     32'd7);
    check("t3_enq_ready", 32'(enq_ready), 32'd1);
    step(1'b1, 9'h140, 1'b0, 1'b0);
    check("t3_count8", 32'(count), 32'd8);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("t3_wrapped_head", 32'(deq_data), 32'h140);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t3_empty", 32'(empty), 32'd1);

    // Test 4: sustained streaming at count 3.
    for (int i = 0; i < 3; i++) step(1'b1, 9'(9'h010 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 9'(9'h013 + i), 1'b1, 1'b0);
    check("t4_count", 32'(count), 32'd3);
    check("t4_head",  32'(deq_data), 32'h024);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("t4_empty", 32'(empty), 32'd1);

    // Test 5: flush with both handshakes asserted.
    for (int i = 0; i < 5; i++) step(1'b1, 9'(9'h060 + i), 1'b0, 1'b0);
    check("t5_count5", 32'(count), 32'd5);
    step(1'b1, 9'h0EE, 1'b1, 1'b1);
    check("t5_count0",    32'(count),     32'd0);
    check("t5_empty",     32'(empty),     32'd1);
    check("t5_deq_valid", 32'(deq_valid), 32'd0);
    step(1'b1, 9'h055, 1'b0, 1'b0);
    check("t5_data55", 32'(deq_data), 32'h055);
    check("t5_count1", 32'(count),    32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t5_empty_end", 32'(empty), 32'd1);

    // Test 6: asynchronous reset between edges at count 4.
    for (int i = 0; i < 4; i++) step(1'b1, 9'(9'h070 + i), 1'b0, 1'b0);
    check("t6_count4", 32'(count), 32'd4);
    #1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
    mcount    = 0;
    exp_q.delete();
    #1;
    check("t6_async_count",     32'(count),     32'd0);
    check("t6_async_deq_valid", 32'(deq_valid), 32'd0);
    check("t6_async_deq_data",  32'(deq_data),  32'd0);
    check("t6_async_empty",     32'(empty),     32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 9'h0AA, 1'b0, 1'b0);
    check("t6_resume_count", 32'(count),    32'd1);
    check("t6_resume_data",  32'(deq_data), 32'h0AA);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t6_resume_empty", 32'(empty), 32'd1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tag_queue_ctrl.md
Name: tag_queue_ctrl

Overview:
Controller that sequences a bank of DEPTH enable-register words (WIDTH bits each) as a circular FIFO. It carries rename/issue tags between out-of-order pipeline stages.
- Generates one-hot per-word write enables, read/write pointers and an occupancy count.
- Provides valid/ready handshakes on both sides, plus a single-cycle flush for branch mispredict recovery.

Parameters:
WIDTH, 9, bits per stored tag word
DEPTH, 8, number of storage words; must be a power of two, at least 2
CNTW, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset; 0 = in reset
enq_valid  input  1  producer presents enq_data
enq_ready  output  1  queue can accept a word this cycle
enq_data  input  WIDTH  tag to enqueue
deq_valid  output  1  deq_data holds the oldest valid word
deq_ready  input  1  consumer takes deq_data this cycle
deq_data  output  WIDTH  oldest stored word
flush  input  1  discard all contents
count  output  CNTW  number of valid words, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Clock and reset: single clock domain, clk. reset is asynchronous and active-low.
- While reset = 0, all of the following hold immediately, independent of clk:
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, full = 0, enq_ready = 1, deq_valid = 0
  - all storage words = 0, so deq_data = 0
- Handshake outputs:
  - enq_ready = !full. It is a function of registered state only; there is no combinational path from deq_ready.
  - deq_valid = !empty.
  - deq_data = word[rd_ptr], combinational from storage, so it is valid in the same cycle as deq_valid.
- Transfers:
  - enq_fire = enq_valid & enq_ready & !flush.
  - deq_fire = deq_valid & deq_ready & !flush.
- Write: on enq_fire, only word[wr_ptr] is enabled and captures enq_data at the next edge. All other words hold.
- Pointers:
  - wr_ptr advances by 1 on enq_fire; rd_ptr advances by 1 on deq_fire.
  - Both wrap modulo DEPTH: the pointer after DEPTH-1 is 0.
- Count:
  - +1 on enq_fire only; -1 on deq_fire only; unchanged when both fire or neither fires.
  - Never exceeds DEPTH and never goes below 0; the handshake rules guarantee this.
- Latency: a word enqueued at edge N is visible on deq_data/deq_valid after edge N, provided it is the oldest word. Minimum enqueue-to-dequeue latency is 1 cycle; there is no fall-through.
- Full with deq_ready = 1: enq_ready is still 0 that cycle, so only the dequeue happens. enq_ready returns to 1 the next cycle.
- Empty with enq_valid = 1: deq_valid is 0, so only the enqueue happens. deq_valid = 1 the next cycle.
- Flush:
  - At the next edge: wr_ptr = rd_ptr = 0, count = 0.
  - enq and deq transfers are suppressed in the flush cycle, even if the handshakes are asserted.
  - Storage contents are left stale.
  - The next cycle behaves exactly like post-reset, except storage is not zeroed.
- Reset mid-operation: state clears asynchronously. Deasserting reset takes effect at the first clk edge after release. In-flight handshakes are dropped.
- Storage words are only ever written through the one-hot enable. No word is written while count == DEPTH.

Decomposition:
- Shared package tag_queue_pkg holds:
  - the tag typedef, logic [WIDTH-1:0]
  - the pointer typedef, logic [$clog2(DEPTH)-1:0]
  - the DEPTH/WIDTH defaults
- Sub-module tag_word_reg: a WIDTH-bit enable register with asynchronous active-low reset to 0. It is instantiated DEPTH times in a generate loop and driven by the one-hot enable vector.
- Pointer, count and flag logic stays in tag_queue_ctrl.

Test Plan:
1. Reset, then enqueue 9'h0A1, 9'h0A2, 9'h0A3 with deq_ready = 0, then dequeue three with enq_valid = 0.
   -> count goes 1, 2, 3, then 2, 1, 0; deq_data reads 0A1, 0A2, 0A3 in order; empty = 1 at the end.
2. Fill with 8 words, 9'h100..9'h107; hold enq_valid = 1 with 9'h1FF.
   -> full = 1, enq_ready = 0, count = 8, 9'h1FF is never stored; dequeue all 8 and get 100..107 in order.
3. Full queue with enq_valid = 1 and deq_ready = 1 in the same cycle.
   -> only the dequeue happens (count 8 to 7); enq_ready = 1 the next cycle; the next enqueue lands in word 0 (wrap).
4. Sustained simultaneous enq/deq for 20 cycles at count = 3, enqueuing incrementing values from 9'h010.
   -> count stays 3; dequeue order matches enqueue order across two pointer wraps.
5. count = 5, then flush = 1 together with enq_valid = 1 and deq_ready = 1.
   -> next cycle count = 0, empty = 1, deq_valid = 0; the flushed enqueue is absent; a later enqueue of 9'h055 is read back as 9'h055.
6. Assert reset = 0 asynchronously between edges at count = 4.
   -> count = 0, deq_valid = 0 and deq_data = 0 immediately, before the next edge; normal operation resumes after release.
